// File: rtl/alu181_pkg.sv
// Shared types and constants for the slice-serial 74181-style ALU.
package alu181_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Common 74181 function codes (FN_SUB with m=0, FN_XOR with m=1 share a code)
  localparam logic [3:0] FN_ADD   = 4'b1001;
  localparam logic [3:0] FN_SUB   = 4'b0110;
  localparam logic [3:0] FN_XOR   = 4'b0110;
  localparam logic [3:0] FN_AND   = 4'b1011;
  localparam logic [3:0] FN_OR    = 4'b1110;
  localparam logic [3:0] FN_PASSA = 4'b1111;

  // Step counter width; at least one bit even when a single step suffices
  function automatic int unsigned step_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181 equivalent, active-high data, active-low carry.
module alu181_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin_n,
  output logic [3:0] f,
  output logic       cout_n
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;

  // The arithmetic result is x + y + carry; the logic result is ~(x ^ y),
  // which reproduces the full 74181 logic table from the same two terms.
  always_comb begin
    x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0000, ~cin_n};
    if (m) begin
      f      = ~(x ^ y);
      cout_n = 1'b1;
    end else begin
      f      = sum[3:0];
      cout_n = ~sum[4];
    end
  end

endmodule

// File: rtl/alu181_seq.sv
// Slice-serial WIDTH-bit 74181 ALU with valid/ready handshakes on both sides.
module alu181_seq
  import alu181_pkg::*;
#(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned SLICES_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin_n,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout_n,
  output logic             aeqb,
  output logic             zero
);

  localparam int unsigned SPC    = SLICES_PER_CYCLE;
  localparam int unsigned CW     = 4 * SPC;
  localparam int unsigned NSTEP  = WIDTH / CW;
  localparam int unsigned STEP_W = step_width(NSTEP);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NSTEP - 1);
  localparam logic [WIDTH-1:0]  CHUNK_MASK = WIDTH'({CW{1'b1}});

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  f_q, f_d;
  logic [3:0]        s_q, s_d;
  logic              m_q, m_d;
  logic              carry_q, carry_d;
  logic              res_valid_q, res_valid_d;

  logic [31:0]       shamt;
  logic [CW-1:0]     a_sh;
  logic [CW-1:0]     b_sh;
  logic [CW-1:0]     chunk_f;
  logic [SPC:0]      chain;

  // Bring the slices selected by the step index down to bit 0
  always_comb begin
    shamt = 32'(step_q) * CW;
    a_sh  = CW'(a_q >> shamt);
    b_sh  = CW'(b_q >> shamt);
  end

  assign chain[0] = carry_q;

  for (genvar i = 0; i < SPC; i++) begin : g_slice
    alu181_slice u_slice (
      .a      (a_sh[4*i +: 4]),
      .b      (b_sh[4*i +: 4]),
      .s      (s_q),
      .m      (m_q),
      .cin_n  (chain[i]),
      .f      (chunk_f[4*i +: 4]),
      .cout_n (chain[i+1])
    );
  end

  // Next-state, operand capture and per-step result merge
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    f_d         = f_q;
    s_d         = s_q;
    m_d         = m_q;
    carry_d     = carry_q;
    res_valid_d = res_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = cin_n;
          step_d  = '0;
          f_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        f_d     = (f_q & ~(CHUNK_MASK << shamt)) | (WIDTH'(chunk_f) << shamt);
        carry_d = chain[SPC];
        step_d  = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          step_d      = '0;
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      carry_q     <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      f_q         <= f_d;
      s_q         <= s_d;
      m_q         <= m_d;
      carry_q     <= carry_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE) && !rst;
  assign res_valid   = res_valid_q;
  assign f           = f_q;
  assign cout_n      = carry_q;
  assign aeqb        = &f_q;
  assign zero        = ~|f_q;

endmodule

// File: tb/tb_alu181_seq.sv
// Scoreboard bench for alu181_seq: one instance with 1 slice/cycle, one with 4.
module tb_alu181_seq;
  import alu181_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sv1, sr1, rv1, rr1, co1, eq1, z1, m1, cin1;
  logic [15:0] a1, b1, f1;
  logic [3:0]  s1;
  logic        sv4, sr4, rv4, rr4, co4, eq4, z4, m4, cin4;
  logic [15:0] a4, b4, f4;
  logic [3:0]  s4;

  alu181_seq #(.WIDTH(16), .SLICES_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .s(s1), .m(m1), .cin_n(cin1),
    .res_valid(rv1), .res_ready(rr1), .f(f1), .cout_n(co1), .aeqb(eq1), .zero(z1)
  );

  alu181_seq #(.WIDTH(16), .SLICES_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4),
    .a(a4), .b(b4), .s(s4), .m(m4), .cin_n(cin4),
    .res_valid(rv4), .res_ready(rr4), .f(f4), .cout_n(co4), .aeqb(eq4), .zero(z4)
  );

  typedef struct {
    int          id;
    logic [15:0] f;
    logic        cout_n;
    int unsigned acc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic rv1_prev = 1'b0;
  logic rv4_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor for the 1-slice instance
  always @(negedge clk) begin
    if (rst) rv1_prev = 1'b0;
    else begin
      if (rv1 && !rv1_prev) begin
        if (q1.size() == 0) chk("spc1_unexpected_valid", 32'(rv1), 32'd0);
        else chk($sformatf("op%0d_latency", q1[0].id), cyc - q1[0].acc, 32'd4);
      end
      if (rv1 && rr1 && q1.size() != 0) begin
        e1 = q1.pop_front();
        chk($sformatf("op%0d_f", e1.id), 32'(f1), 32'(e1.f));
        chk($sformatf("op%0d_cout_n", e1.id), 32'(co1), 32'(e1.cout_n));
        chk($sformatf("op%0d_zero", e1.id), 32'(z1), 32'(e1.f == 16'h0000));
        chk($sformatf("op%0d_aeqb", e1.id), 32'(eq1), 32'(e1.f == 16'hFFFF));
      end
      rv1_prev = rv1;
    end
  end

  // Monitor for the 4-slice instance
  always @(negedge clk) begin
    if (rst) rv4_prev = 1'b0;
    else begin
      if (rv4 && !rv4_prev) begin
        if (q4.size() == 0) chk("spc4_unexpected_valid", 32'(rv4), 32'd0);
        else chk($sformatf("op%0d_latency", q4[0].id), cyc - q4[0].acc, 32'd1);
      end
      if (rv4 && rr4 && q4.size() != 0) begin
        e4 = q4.pop_front();
        chk($sformatf("op%0d_f", e4.id), 32'(f4), 32'(e4.f));
        chk($sformatf("op%0d_cout_n", e4.id), 32'(co4), 32'(e4.cout_n));
        chk($sformatf("op%0d_zero", e4.id), 32'(z4), 32'(e4.f == 16'h0000));
        chk($sformatf("op%0d_aeqb", e4.id), 32'(eq4), 32'(e4.f == 16'hFFFF));
      end
      rv4_prev = rv4;
    end
  end

  task automatic issue(input bit w4, input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic m, input logic cin,
                       input logic [15:0] ef, input logic ec);
    exp_t e;
    bit ok = 1'b0;
    @(posedge clk); #1;
    if (w4) begin sv4 = 1'b1; a4 = a; b4 = b; s4 = s; m4 = m; cin4 = cin; end
    else    begin sv1 = 1'b1; a1 = a; b1 = b; s1 = s; m1 = m; cin1 = cin; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((w4 ? sr4 : sr1) === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (w4) sv4 = 1'b0; else sv1 = 1'b0;
    if (!ok) chk($sformatf("op%0d_accept_timeout", id), 32'd0, 32'd1);
    else begin
      e.id = id; e.f = ef; e.cout_n = ec; e.acc = cyc;
      if (w4) q4.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q4.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    sv1 = 0; a1 = '0; b1 = '0; s1 = '0; m1 = 0; cin1 = 1; rr1 = 1;
    sv4 = 0; a4 = '0; b4 = '0; s4 = '0; m4 = 0; cin4 = 1; rr4 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("start_ready_in_reset", 32'(sr1), 32'd0);
    chk("start_ready4_in_reset", 32'(sr4), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_start_ready", 32'(sr1), 32'd1);
    chk("rst_res_valid", 32'(rv1), 32'd0);
    chk("rst_f", 32'(f1), 32'd0);
    chk("rst_cout_n", 32'(co1), 32'd1);
    chk("rst4_start_ready", 32'(sr4), 32'd1);
    chk("rst4_res_valid", 32'(rv4), 32'd0);

    // Arithmetic and logic vectors on the 1-slice instance
    issue(0, 1,  16'h1234, 16'h0FFF, FN_ADD,   0, 1, 16'h2233, 1);
    issue(0, 2,  16'hFFFF, 16'h0001, FN_ADD,   0, 1, 16'h0000, 0);
    issue(0, 3,  16'h5A5A, 16'h5A5A, FN_SUB,   0, 1, 16'hFFFF, 1);
    issue(0, 4,  16'h5A5A, 16'h5A5A, FN_SUB,   0, 0, 16'h0000, 0);
    issue(0, 5,  16'hF0F0, 16'hFF00, FN_XOR,   1, 0, 16'h0FF0, 1);
    issue(0, 6,  16'h0010, 16'h0001, FN_SUB,   0, 0, 16'h000F, 0);
    issue(0, 7,  16'h1000, 16'hABCD, 4'b1111,  0, 1, 16'h0FFF, 0);
    issue(0, 8,  16'h0000, 16'hABCD, 4'b1111,  0, 1, 16'hFFFF, 1);
    issue(0, 9,  16'h8001, 16'h1234, 4'b1100,  0, 1, 16'h0002, 0);
    issue(0, 10, 16'h00FF, 16'h5555, 4'b0000,  0, 0, 16'h0100, 1);
    issue(0, 11, 16'h00F0, 16'h0030, 4'b0100,  0, 1, 16'h01B0, 1);
    issue(0, 12, 16'h1234, 16'h0FF0, FN_AND,   1, 1, 16'h0230, 1);
    issue(0, 13, 16'h1234, 16'h0FF0, FN_OR,    1, 1, 16'h1FF4, 1);
    issue(0, 14, 16'h1234, 16'h0FF0, 4'b0000,  1, 1, 16'hEDCB, 1);
    issue(0, 15, 16'h1234, 16'h0FF0, 4'b1100,  1, 1, 16'hFFFF, 1);
    issue(0, 16, 16'h1234, 16'h0FF0, 4'b0011,  1, 0, 16'h0000, 1);
    issue(0, 17, 16'hC3A5, 16'h0FF0, FN_PASSA, 1, 0, 16'hC3A5, 1);

    // Four slices per cycle
    issue(1, 20, 16'h1234, 16'h0FFF, FN_ADD,   0, 1, 16'h2233, 1);
    issue(1, 21, 16'hFFFF, 16'h0001, FN_ADD,   0, 1, 16'h0000, 0);
    issue(1, 22, 16'h5A5A, 16'h5A5A, FN_SUB,   0, 0, 16'h0000, 0);
    drain();

    // Backpressure: result held while new requests are offered
    @(posedge clk); #1 rr1 = 1'b0;
    issue(0, 30, 16'h0F0F, 16'h00F1, FN_ADD, 0, 1, 16'h1000, 1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rv1 === 1'b1) begin seen = 1'b1; break; end
    end
    chk("bp_wait_valid", 32'(seen), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sv1 = ~sv1; a1 = 16'h7777 + 16'(i); b1 = 16'h1111; s1 = FN_ADD; m1 = 0; cin1 = 0;
      @(negedge clk);
      chk($sformatf("bp%0d_f", i), 32'(f1), 32'h1000);
      chk($sformatf("bp%0d_cout_n", i), 32'(co1), 32'd1);
      chk($sformatf("bp%0d_start_ready", i), 32'(sr1), 32'd0);
      chk($sformatf("bp%0d_res_valid", i), 32'(rv1), 32'd1);
    end
    @(posedge clk); #1 sv1 = 1'b0; rr1 = 1'b1;
    issue(0, 31, 16'h0001, 16'h0002, FN_ADD, 0, 1, 16'h0003, 1);
    drain();

    // Reset in the middle of RUN, after two steps
    @(posedge clk); #1;
    sv1 = 1'b1; a1 = 16'h1234; b1 = 16'h0FFF; s1 = FN_ADD; m1 = 0; cin1 = 1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sr1 === 1'b1) begin seen = 1'b1; break; end
    end
    chk("midrun_accept", 32'(seen), 32'd1);
    @(posedge clk); #1 sv1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrun_start_ready_in_reset", 32'(sr1), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_res_valid", 32'(rv1), 32'd0);
    chk("midrun_f", 32'(f1), 32'd0);
    chk("midrun_start_ready", 32'(sr1), 32'd1);
    chk("midrun_cout_n", 32'(co1), 32'd1);
    issue(0, 40, 16'h1234, 16'h0FFF, FN_ADD, 0, 1, 16'h2233, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
